pulse_period_monitor: RTL and testbench
=======================================

Name: pulse_period_monitor

Overview:
- Receive-side checker for the periodic one-cycle tick emitted by the free-running `delay2` divider.
- Measures the interval between successive ticks and compares it against the expected period N+1 within a tolerance window.
- Reports lock status, early and late (missing-tick) errors, and a saturating error count.
- Sits directly downstream of the tick generator, in the same clock domain, as a health monitor.

Parameters:
- N, 750: generator terminal count. Expected tick period P = N+1 cycles.
- CBITS, 11: interval counter width. Must satisfy 2^CBITS > N+1+TOL.
- TOL, 2: accepted deviation in cycles. An interval I is good iff P-TOL <= I <= P+TOL.
- LOCK_CNT, 4: number of consecutive good intervals required to assert locked.
- EBITS, 8: error counter width.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- sig, input, 1: tick from the generator. One-cycle pulse, sampled on posedge clk.
- clear_err, input, 1: synchronous clear of err_cnt.
- locked, output, 1: level; tick stream is within tolerance.
- early_err, output, 1: one-cycle pulse; tick arrived with I < P-TOL.
- late_err, output, 1: one-cycle pulse; no tick by I = P+TOL.
- last_period, output, CBITS: last measured interval I.
- err_cnt, output, EBITS: saturating count of early plus late errors.

Behaviour:
- General
  - All outputs are registered and update on the posedge at which the triggering condition is sampled.
  - rst has priority over every other input.
- Reset values
  - state=SEARCH, cnt=0, good=0, locked=0, early_err=0, late_err=0, last_period=0, err_cnt=0.
- Interval counter cnt
  - Cleared to 0 on any posedge with sig=1.
  - Otherwise increments by 1, saturating at P+TOL.
  - Measured interval is I = cnt+1 at a sampled tick.
  - Example: ticks at edges t and t+N+1 give I = N+1.
- States
  - SEARCH: no reference tick yet.
    - On sig: go to TRACK, good=0, cnt=0.
    - No interval check in SEARCH; last_period is unchanged.
  - TRACK:
    - On sig with I good: last_period=I, good=good+1. If good+1 == LOCK_CNT, go to LOCKED and set locked=1.
    - On sig with I < P-TOL: early_err=1, err_cnt+1, last_period=I, good=0. Stay in TRACK; the new tick becomes the reference.
    - When cnt == P+TOL with no sig sampled that edge: late_err=1, err_cnt+1, good=0. Go to SEARCH.
  - LOCKED: same checks as TRACK.
    - Good tick: stay in LOCKED; good holds at LOCK_CNT.
    - Early tick: locked=0, go to TRACK.
    - Late: locked=0, go to SEARCH.
- Boundaries and simultaneous events
  - I = P-TOL and I = P+TOL are good.
  - A tick on the same edge at which cnt reaches P+TOL is a good tick; late_err is not raised.
  - early_err and late_err are never high in the same cycle.
  - Each error pulse lasts exactly one cycle.
  - err_cnt saturates at 2^EBITS-1.
  - clear_err together with an error on the same edge: err_cnt = 1 (clear first, then increment).
  - clear_err alone: err_cnt = 0. It affects no other state.
  - rst mid-interval or while locked: full return to reset values on that edge; the next tick is treated as a SEARCH reference.
  - sig high on consecutive cycles: the second sample gives I = 1. That is an early error in TRACK/LOCKED and a reference in SEARCH.

Test Plan (N=750, TOL=2, LOCK_CNT=4, P=751):
- Free-running `delay2` drives sig after common rst.
  - -> locked rises on the edge of the 5th tick.
  - -> last_period = 751.
  - -> err_cnt stays 0 over 20 ticks.
- Locked; inject ticks with I=749, then I=753.
  - -> both good, locked stays 1, last_period = 749 then 753.
- Locked; inject tick with I=748.
  - -> early_err one cycle, err_cnt=1, locked=0, state TRACK.
  - -> relock after 4 further good intervals.
- Locked; suppress the next tick.
  - -> late_err one cycle at the edge where cnt = 753 (I would be 754).
  - -> locked=0, state SEARCH.
  - -> the next tick is only a reference: no error, locked=0.
- 300 consecutive early ticks with EBITS=8.
  - -> err_cnt saturates at 255.
  - -> then clear_err with a simultaneous early tick gives err_cnt = 1.
- rst asserted for 1 cycle while locked mid-interval.
  - -> all outputs return to reset values next cycle.
  - -> the following tick produces no error.

Source files
------------

// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor
//   Health monitor for a periodic one-cycle tick (expected period P = N+1
//   cycles). Each tick-to-tick interval I is classified as good
//   (P-TOL <= I <= P+TOL), early (I < P-TOL) or late (no tick by I = P+TOL).
//   After LOCK_CNT consecutive good intervals the stream is declared locked.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset, priority over all inputs
//   sig          tick input, one-cycle pulse
//   clear_err    synchronous clear of err_cnt (applied before any increment)
//   locked       level, stream within tolerance
//   early_err    one-cycle pulse, tick arrived with I < P-TOL
//   late_err     one-cycle pulse, no tick by I = P+TOL
//   last_period  last measured interval I (not updated by a late event)
//   err_cnt      saturating count of early plus late errors
//   dbg_state    current FSM state (0 SEARCH, 1 TRACK, 2 LOCKED)
module pulse_period_monitor #(
    parameter int N        = 750,
    parameter int CBITS    = 11,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4,
    parameter int EBITS    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             clear_err,
    output logic             locked,
    output logic             early_err,
    output logic             late_err,
    output logic [CBITS-1:0] last_period,
    output logic [EBITS-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    localparam int P     = N + 1;
    localparam int PMIN  = P - TOL;
    localparam int PMAX  = P + TOL;
    localparam int GBITS = $clog2(LOCK_CNT + 1);

    localparam logic [CBITS-1:0] CNT_MAX   = CBITS'(PMAX);
    localparam logic [CBITS-1:0] I_MIN     = CBITS'(PMIN);
    localparam logic [GBITS-1:0] GOOD_LOCK = GBITS'(LOCK_CNT);
    localparam logic [EBITS-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [GBITS-1:0] good_q, good_d;
    logic             locked_q, locked_d;
    logic             early_q, early_d;
    logic             late_q, late_d;
    logic [CBITS-1:0] last_q, last_d;
    logic [EBITS-1:0] err_q, err_d;

    logic [CBITS-1:0] interval;
    logic [GBITS-1:0] good_inc;
    logic [EBITS-1:0] err_base;
    logic             err_event;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        locked_d  = locked_q;
        early_d   = 1'b0;
        late_d    = 1'b0;
        last_d    = last_q;
        err_event = 1'b0;
        interval  = cnt_q + CBITS'(1);
        good_inc  = good_q + GBITS'(1);

        // Interval counter: a tick restarts it, otherwise it climbs and
        // parks at P+TOL (only reachable in SEARCH once tracking is lost).
        if (sig) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CBITS'(1);
        end

        case (state_q)
            SEARCH: begin
                if (sig) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK, LOCKED: begin
                if (cnt_q == CNT_MAX) begin
                    // Window closed. A tick arriving exactly now is already
                    // out of window, so it only serves as the new reference.
                    late_d    = 1'b1;
                    err_event = 1'b1;
                    good_d    = '0;
                    locked_d  = 1'b0;
                    state_d   = sig ? TRACK : SEARCH;
                end else if (sig) begin
                    last_d = interval;
                    if (interval < I_MIN) begin
                        early_d   = 1'b1;
                        err_event = 1'b1;
                        good_d    = '0;
                        locked_d  = 1'b0;
                        state_d   = TRACK;
                    end else if (state_q == TRACK) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_LOCK) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        // Clear takes effect first, so clear plus error yields 1.
        err_base = clear_err ? '0 : err_q;
        err_d    = (err_event && (err_base != ERR_MAX)) ? err_base + EBITS'(1) : err_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            last_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            early_q  <= early_d;
            late_q   <= late_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign locked      = locked_q;
    assign early_err   = early_q;
    assign late_err    = late_q;
    assign last_period = last_q;
    assign err_cnt     = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
module tb_pulse_period_monitor;

    localparam int N        = 750;
    localparam int CBITS    = 11;
    localparam int TOL      = 2;
    localparam int LOCK_CNT = 4;
    localparam int EBITS    = 8;
    localparam int P        = N + 1;
    localparam int EMAX     = (1 << EBITS) - 1;
    localparam int W        = 3 + CBITS + EBITS + 2;

    // clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;
    logic clear_err = 1'b0;
    logic             locked;
    logic             early_err;
    logic             late_err;
    logic [CBITS-1:0] last_period;
    logic [EBITS-1:0] err_cnt;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    pulse_period_monitor #(
        .N(N), .CBITS(CBITS), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .EBITS(EBITS)
    ) dut (
        .clk(clk), .rst(rst), .sig(sig), .clear_err(clear_err),
        .locked(locked), .early_err(early_err), .late_err(late_err),
        .last_period(last_period), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: works on tick timestamps (cycle numbers), not on
    // a counter. Mode 0 = no reference, 1 = tracking, 2 = locked.
    int cyc    = 0;
    int m_mode = 0;
    int m_ref  = 0;
    int m_good = 0;
    int m_last = 0;
    int m_err  = 0;
    bit m_locked = 0;
    bit m_early  = 0;
    bit m_late   = 0;

    task automatic model_edge(input bit s, input bit r, input bit c);
        int iv;
        bit err_now;
        m_early = 0;
        m_late  = 0;
        err_now = 0;
        if (r) begin
            m_mode = 0; m_good = 0; m_locked = 0; m_last = 0; m_err = 0;
        end else begin
            if (m_mode == 0) begin
                if (s) begin m_mode = 1; m_ref = cyc; m_good = 0; end
            end else begin
                iv = cyc - m_ref;
                if (iv > P + TOL) begin
                    m_late = 1; err_now = 1; m_good = 0; m_locked = 0;
                    if (s) begin m_mode = 1; m_ref = cyc; end
                    else m_mode = 0;
                end else if (s) begin
                    m_last = iv;
                    m_ref  = cyc;
                    if (iv < P - TOL) begin
                        m_early = 1; err_now = 1; m_good = 0; m_locked = 0; m_mode = 1;
                    end else if (m_mode == 1) begin
                        m_good++;
                        if (m_good == LOCK_CNT) begin m_mode = 2; m_locked = 1; end
                    end
                end
            end
            if (c) m_err = 0;
            if (err_now && m_err < EMAX) m_err++;
        end
        cyc++;
    endtask

    function automatic logic [W-1:0] exp_vec();
        return {m_locked, m_early, m_late, CBITS'(m_last), EBITS'(m_err), 2'(m_mode)};
    endfunction

    function automatic logic [W-1:0] obs();
        return {locked, early_err, late_err, last_period, err_cnt, dbg_state};
    endfunction

    // driver tasks
    task automatic step(input bit s, input bit r, input bit c);
        sig = s; rst = r; clear_err = c;
        @(posedge clk);
        model_edge(s, r, c);
        #1;
    endtask

    // Idle iv-1 cycles, then tick, so the tick lands iv cycles after the last one.
    task automatic gap(input int iv, input bit c);
        repeat (iv - 1) step(0, 0, 0);
        step(1, 0, c);
    endtask

    task automatic test_reset();
        step(0, 1, 0);
        step(0, 1, 0);
        n_vec++;
        if (obs() !== '0) begin
            n_bad++; $display("FAIL reset: got %h want %h", obs(), {W{1'b0}});
        end
    endtask

    task automatic test_generator_lock();
        repeat (3) step(0, 0, 0);
        for (int t = 1; t <= 20; t++) begin
            if (t == 1) step(1, 0, 0);
            else gap(P, 0);
            n_vec++;
            if (obs() !== exp_vec()) begin
                n_bad++; $display("FAIL gen_tick%0d: got %h want %h", t, obs(), exp_vec());
            end
            n_vec++;
            if (locked !== (t >= 5)) begin
                n_bad++; $display("FAIL gen_lock%0d: got %0b want %0b", t, locked, (t >= 5));
            end
        end
        n_vec++;
        if (last_period !== CBITS'(751) || err_cnt !== EBITS'(0)) begin
            n_bad++; $display("FAIL gen_final: got last=%0d err=%0d want last=751 err=0", last_period, err_cnt);
        end
    endtask

    task automatic test_tolerance_edges();
        int ivs[2] = '{749, 753};
        for (int k = 0; k < 2; k++) begin
            gap(ivs[k], 0);
            n_vec++;
            if (last_period !== CBITS'(ivs[k]) || locked !== 1'b1 || early_err !== 1'b0) begin
                n_bad++; $display("FAIL tol_edge%0d: got last=%0d locked=%0b early=%0b want last=%0d locked=1 early=0",
                                  k, last_period, locked, early_err, ivs[k]);
            end
            n_vec++;
            if (obs() !== exp_vec()) begin
                n_bad++; $display("FAIL tol_model%0d: got %h want %h", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_early();
        gap(748, 0);
        n_vec++;
        if (early_err !== 1'b1 || err_cnt !== EBITS'(1) || locked !== 1'b0 || dbg_state !== 2'd1) begin
            n_bad++; $display("FAIL early_tick: got e=%0b err=%0d lk=%0b st=%0d want e=1 err=1 lk=0 st=1",
                              early_err, err_cnt, locked, dbg_state);
        end
        step(0, 0, 0);
        n_vec++;
        if (early_err !== 1'b0) begin
            n_bad++; $display("FAIL early_pulse: got %0b want 0", early_err);
        end
        for (int k = 1; k <= 4; k++) begin
            gap((k == 1) ? P - 1 : P, 0);
            n_vec++;
            if (locked !== (k == 4) || obs() !== exp_vec()) begin
                n_bad++; $display("FAIL relock%0d: got %h want %h", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_late();
        for (int k = 1; k <= P + TOL; k++) begin
            step(0, 0, 0);
            n_vec++;
            if (obs() !== exp_vec()) begin
                n_bad++; $display("FAIL late_wait%0d: got %h want %h", k, obs(), exp_vec());
            end
        end
        step(0, 0, 0);
        n_vec++;
        if (late_err !== 1'b1 || early_err !== 1'b0 || locked !== 1'b0 || dbg_state !== 2'd0 || err_cnt !== EBITS'(2)) begin
            n_bad++; $display("FAIL late_pulse: got %h want late=1 early=0 lk=0 st=0 err=2", obs());
        end
        step(0, 0, 0);
        n_vec++;
        if (late_err !== 1'b0) begin
            n_bad++; $display("FAIL late_once: got %0b want 0", late_err);
        end
        gap(100, 0);
        n_vec++;
        if (early_err !== 1'b0 || late_err !== 1'b0 || locked !== 1'b0 || dbg_state !== 2'd1 || err_cnt !== EBITS'(2)) begin
            n_bad++; $display("FAIL late_ref: got %h want no error, state 1, err 2", obs());
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 300; k++) begin
            step(1, 0, 0);
            n_vec++;
            if (early_err !== 1'b1 || obs() !== exp_vec()) begin
                n_bad++; $display("FAIL sat_step%0d: got %h want %h", k, obs(), exp_vec());
            end
        end
        n_vec++;
        if (err_cnt !== EBITS'(EMAX)) begin
            n_bad++; $display("FAIL sat_value: got %0d want %0d", err_cnt, EMAX);
        end
        step(1, 0, 1);
        n_vec++;
        if (err_cnt !== EBITS'(1) || early_err !== 1'b1) begin
            n_bad++; $display("FAIL clear_with_err: got err=%0d e=%0b want err=1 e=1", err_cnt, early_err);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) gap(P, 0);
        n_vec++;
        if (locked !== 1'b1) begin
            n_bad++; $display("FAIL rst_prelock: got %0b want 1", locked);
        end
        repeat (300) step(0, 0, 0);
        step(0, 1, 0);
        n_vec++;
        if (obs() !== '0) begin
            n_bad++; $display("FAIL rst_mid: got %h want %h", obs(), {W{1'b0}});
        end
        repeat (200) step(0, 0, 0);
        step(1, 0, 0);
        n_vec++;
        if (early_err !== 1'b0 || late_err !== 1'b0 || dbg_state !== 2'd1 || err_cnt !== EBITS'(0)) begin
            n_bad++; $display("FAIL rst_ref: got %h want no error, state 1, err 0", obs());
        end
        gap(P, 0);
        n_vec++;
        if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL rst_next: got %h want %h", obs(), exp_vec());
        end
    endtask

    task automatic test_random();
        int iv;
        int kind;
        bit c;
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       iv = $urandom_range(1, P - TOL - 1);
                3:       iv = $urandom_range(P + TOL + 1, P + TOL + 30);
                default: iv = $urandom_range(P - TOL, P + TOL);
            endcase
            c = ($urandom_range(0, 7) == 0);
            for (int k = 1; k <= iv; k++) begin
                step(k == iv, 0, (k == iv) && c);
                n_vec++;
                if (obs() !== exp_vec()) begin
                    n_bad++; $display("FAIL rand%0d_cyc%0d: got %h want %h", t, k, obs(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_generator_lock();
        test_tolerance_edges();
        test_early();
        test_late();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
